alarm_timer: RTL and testbench

Elapsed-time alarm service answering the `alarm` calls made by the timeout-handling process model. It accepts arm/cancel requests over a req/ack handshake, returns the previously remaining time, and counts down one step per time slice. On expiry it emits a one-cycle `ring` pulse and holds a pending-signal flag until the process acknowledges delivery. It sits between the scheduler's time-slice tick and the process FSM as the signal-generating end of the alarm interface.

---
 rtl/alarm_timer.sv | 116 +++++++++++
 tb/tb_alarm_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
// Elapsed-time alarm: arm/cancel over a req/ack handshake, tick-driven countdown,
// one-cycle ring on expiry and a pending-signal flag held until the process takes it.
module alarm_timer #(
  parameter int MSB = 3
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         tick,
  input  logic         req,
  input  logic [MSB:0] reqValue,
  output logic         ack,
  output logic [MSB:0] prevValue,
  output logic [MSB:0] timeToAlarm,
  output logic         ring,
  output logic         sigPending,
  input  logic         sigAck,
  output logic         sigOverrun
);

  localparam int W = MSB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         ack_q;
  logic [MSB:0] time_q, time_d;
  logic [MSB:0] prev_q, prev_d;
  logic         pend_q, pend_d;
  logic         ovr_q, ovr_d;
  logic         accept;
  logic         expire;

  // A request held across its own ack is ignored, so every accept costs two cycles.
  assign accept = req & ~ack_q;
  // An accept in the same cycle swallows the tick, so it can never cause an expiry.
  assign expire = ~accept & tick & (time_q == W'(1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (reqValue != '0) ? ARMED : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   state_d = expire ? EXPIRED : ARMED;
        EXPIRED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ring        = (state_q == EXPIRED);
    ack         = ack_q;
    prevValue   = prev_q;
    timeToAlarm = time_q;
    sigPending  = pend_q;
    sigOverrun  = ovr_q;
  end

  always_comb begin
    time_d = time_q;
    prev_d = prev_q;
    if (accept) begin
      time_d = reqValue;
      prev_d = time_q;
    end else if (tick && (time_q != '0)) begin
      time_d = time_q - W'(1);
    end
  end

  // sigAck retires the old signal even when a new expiry lands in the same cycle.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (sigAck) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (expire) begin
      pend_d = 1'b1;
      if (pend_q && !sigAck) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ack_q  <= 1'b0;
      time_q <= '0;
      prev_q <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ack_q  <= accept;
      time_q <= time_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Bench for alarm_timer: directed scenarios with fixed expectations, then random
// traffic checked against a behavioural model of the alarm service.
module tb_alarm_timer;
  localparam int MSB = 3;

  logic         clock = 1'b0;
  logic         resetN = 1'b1;
  logic         tick = 1'b0;
  logic         req = 1'b0;
  logic         sigAck = 1'b0;
  logic [MSB:0] reqValue = '0;
  logic         ack, ring, sigPending, sigOverrun;
  logic [MSB:0] prevValue, timeToAlarm;

  int vectors = 0;
  int errors = 0;

  // Behavioural model of the service as seen from outside.
  logic [MSB:0] m_time = '0, m_prev = '0;
  logic         m_ack = 1'b0, m_ring = 1'b0, m_pend = 1'b0, m_ovr = 1'b0;

  alarm_timer #(.MSB(MSB)) dut (
    .clock(clock), .resetN(resetN), .tick(tick), .req(req), .reqValue(reqValue),
    .ack(ack), .prevValue(prevValue), .timeToAlarm(timeToAlarm), .ring(ring),
    .sigPending(sigPending), .sigAck(sigAck), .sigOverrun(sigOverrun)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_time = '0; m_prev = '0; m_ack = 0; m_ring = 0; m_pend = 0; m_ovr = 0;
  endtask

  // One rising edge; the model advances on the same inputs, outputs settle by +1.
  task automatic clk();
    bit taken, fired, old_pend;
    @(posedge clock);
    taken = req && !m_ack;
    fired = !taken && tick && (m_time == 1);
    old_pend = m_pend;
    m_ring = fired;
    m_ack = taken;
    if (taken) begin
      m_prev = m_time;
      m_time = reqValue;
    end else if (tick && m_time > 0) begin
      m_time = m_time - 1;
    end
    if (sigAck) begin m_pend = 0; m_ovr = 0; end
    if (fired) begin
      m_pend = 1;
      if (old_pend && !sigAck) m_ovr = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 resetN = 1'b0;
    #1;
    vectors++; if ({ack, ring, sigPending, sigOverrun} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b need 0000", {ack, ring, sigPending, sigOverrun}); end
    vectors++; if ({prevValue, timeToAlarm} !== '0) begin errors++;
      $display("FAIL reset_values got prev=%0d time=%0d need 0/0", prevValue, timeToAlarm); end
    req = 1'b1; reqValue = 4'd7;
    @(posedge clock); #1;
    vectors++; if (ack !== 1'b0 || timeToAlarm !== '0) begin errors++;
      $display("FAIL reset_hold got ack=%b time=%0d need 0/0", ack, timeToAlarm); end
    req = 1'b0; reqValue = '0;
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    req = 1; reqValue = 4'd3; tick = 1;
    clk();
    vectors++; if (ack !== 1 || prevValue !== 4'd0 || timeToAlarm !== 4'd3) begin errors++;
      $display("FAIL basic_accept got ack=%b prev=%0d time=%0d need 1/0/3", ack, prevValue, timeToAlarm); end
    req = 0;
    clk();
    vectors++; if (ack !== 0 || timeToAlarm !== 4'd2 || ring !== 0) begin errors++;
      $display("FAIL basic_t2 got ack=%b time=%0d ring=%b need 0/2/0", ack, timeToAlarm, ring); end
    clk();
    vectors++; if (timeToAlarm !== 4'd1 || ring !== 0) begin errors++;
      $display("FAIL basic_t3 got time=%0d ring=%b need 1/0", timeToAlarm, ring); end
    clk();
    vectors++; if (ring !== 1 || sigPending !== 1 || timeToAlarm !== 4'd0) begin errors++;
      $display("FAIL basic_expire got ring=%b pend=%b time=%0d need 1/1/0", ring, sigPending, timeToAlarm); end
    clk();
    vectors++; if (ring !== 0 || sigPending !== 1 || timeToAlarm !== 4'd0) begin errors++;
      $display("FAIL basic_idle got ring=%b pend=%b time=%0d need 0/1/0", ring, sigPending, timeToAlarm); end
    tick = 0; sigAck = 1;
    clk();
    sigAck = 0;
    vectors++; if (sigPending !== 0 || sigOverrun !== 0) begin errors++;
      $display("FAIL basic_sigack got pend=%b ovr=%b need 0/0", sigPending, sigOverrun); end
  endtask

  task automatic test_cancel();
    req = 1; reqValue = 4'd5; tick = 0;
    clk();
    req = 0; tick = 1;
    clk(); clk();
    vectors++; if (timeToAlarm !== 4'd3) begin errors++;
      $display("FAIL cancel_pre got time=%0d need 3", timeToAlarm); end
    tick = 0; req = 1; reqValue = 4'd0;
    clk();
    vectors++; if (ack !== 1 || prevValue !== 4'd3 || timeToAlarm !== 4'd0) begin errors++;
      $display("FAIL cancel_ack got ack=%b prev=%0d time=%0d need 1/3/0", ack, prevValue, timeToAlarm); end
    req = 0; tick = 1;
    for (int i = 0; i < 6; i++) begin
      clk();
      vectors++; if (ring !== 0 || sigPending !== 0 || timeToAlarm !== 0) begin errors++;
        $display("FAIL cancel_quiet cyc %0d got ring=%b pend=%b time=%0d need 0/0/0", i, ring, sigPending, timeToAlarm); end
    end
    tick = 0;
  endtask

  task automatic test_tick_accept();
    req = 1; reqValue = 4'd2;
    clk();
    req = 0; tick = 1;
    clk();
    req = 1; reqValue = 4'd4;
    clk();
    vectors++; if (ack !== 1 || prevValue !== 4'd1 || timeToAlarm !== 4'd4 || ring !== 0) begin errors++;
      $display("FAIL tickacc got ack=%b prev=%0d time=%0d ring=%b need 1/1/4/0", ack, prevValue, timeToAlarm, ring); end
    req = 0; tick = 0;
    clk();
    vectors++; if (ring !== 0 || sigPending !== 0 || timeToAlarm !== 4'd4) begin errors++;
      $display("FAIL tickacc_after got ring=%b pend=%b time=%0d need 0/0/4", ring, sigPending, timeToAlarm); end
    req = 1; reqValue = 4'd0;
    clk();
    req = 0;
    clk();
  endtask

  task automatic arm_one_and_fire();
    req = 1; reqValue = 4'd1; tick = 0;
    clk();
    req = 0; tick = 1;
    clk();
    tick = 0;
  endtask

  task automatic test_overrun();
    arm_one_and_fire();
    vectors++; if (ring !== 1 || sigPending !== 1 || sigOverrun !== 0) begin errors++;
      $display("FAIL ovr_first got ring=%b pend=%b ovr=%b need 1/1/0", ring, sigPending, sigOverrun); end
    arm_one_and_fire();
    vectors++; if (ring !== 1 || sigPending !== 1 || sigOverrun !== 1) begin errors++;
      $display("FAIL ovr_second got ring=%b pend=%b ovr=%b need 1/1/1", ring, sigPending, sigOverrun); end
    sigAck = 1;
    clk();
    sigAck = 0;
    vectors++; if (sigPending !== 0 || sigOverrun !== 0 || ring !== 0) begin errors++;
      $display("FAIL ovr_clear got pend=%b ovr=%b ring=%b need 0/0/0", sigPending, sigOverrun, ring); end
    arm_one_and_fire();
    req = 1; reqValue = 4'd1;
    clk();
    req = 0; tick = 1; sigAck = 1;
    clk();
    tick = 0; sigAck = 0;
    vectors++; if (ring !== 1 || sigPending !== 1 || sigOverrun !== 0) begin errors++;
      $display("FAIL ovr_coincide got ring=%b pend=%b ovr=%b need 1/1/0", ring, sigPending, sigOverrun); end
    sigAck = 1;
    clk();
    sigAck = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    req = 1; reqValue = 4'd2; tick = 0;
    for (int i = 0; i < 4; i++) begin
      clk();
      acks[i] = ack;
      if (i == 2) begin
        vectors++; if (prevValue !== 4'd2 || timeToAlarm !== 4'd2) begin errors++;
          $display("FAIL b2b_prev got prev=%0d time=%0d need 2/2", prevValue, timeToAlarm); end
      end
    end
    req = 0;
    vectors++; if (acks !== 4'b0101) begin errors++;
      $display("FAIL b2b_ack got %b need 0101 (lsb first)", acks); end
  endtask

  task automatic test_async_reset();
    arm_one_and_fire();
    req = 1; reqValue = 4'd3;
    clk();
    req = 0; tick = 1;
    clk();
    vectors++; if (timeToAlarm !== 4'd2 || sigPending !== 1) begin errors++;
      $display("FAIL areset_pre got time=%0d pend=%b need 2/1", timeToAlarm, sigPending); end
    #2 resetN = 0;
    #1;
    model_reset();
    vectors++; if ({ack, ring, sigPending, sigOverrun, prevValue, timeToAlarm} !== '0) begin errors++;
      $display("FAIL areset_now got ack=%b ring=%b pend=%b ovr=%b prev=%0d time=%0d need all 0",
               ack, ring, sigPending, sigOverrun, prevValue, timeToAlarm); end
    @(posedge clock); #1;
    resetN = 1;
    for (int i = 0; i < 6; i++) begin
      clk();
      vectors++; if (ring !== 0 || timeToAlarm !== 0) begin errors++;
        $display("FAIL areset_quiet cyc %0d got ring=%b time=%0d need 0/0", i, ring, timeToAlarm); end
    end
    tick = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req      = ($urandom_range(0, 2) == 0);
      reqValue = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) reqValue = 4'($urandom_range(0, 2));
      tick     = ($urandom_range(0, 3) != 0);
      sigAck   = ($urandom_range(0, 5) == 0);
      clk();
      vectors++; if (ack !== m_ack) begin errors++;
        $display("FAIL rand_ack cyc %0d got %b need %b", i, ack, m_ack); end
      vectors++; if (timeToAlarm !== m_time) begin errors++;
        $display("FAIL rand_time cyc %0d got %0d need %0d", i, timeToAlarm, m_time); end
      vectors++; if (prevValue !== m_prev) begin errors++;
        $display("FAIL rand_prev cyc %0d got %0d need %0d", i, prevValue, m_prev); end
      vectors++; if (ring !== m_ring) begin errors++;
        $display("FAIL rand_ring cyc %0d got %b need %b", i, ring, m_ring); end
      vectors++; if (sigPending !== m_pend) begin errors++;
        $display("FAIL rand_pend cyc %0d got %b need %b", i, sigPending, m_pend); end
      vectors++; if (sigOverrun !== m_ovr) begin errors++;
        $display("FAIL rand_ovr cyc %0d got %b need %b", i, sigOverrun, m_ovr); end
    end
    req = 0; tick = 0; sigAck = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_tick_accept();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running need finished");
    $fatal(1, "watchdog");
  end

endmodule
